adder_16: RTL and testbench

ADDER_16 -- requirements
Module: adder_16

---
 rtl/adder_pkg.sv | 25 ++
 rtl/cla4_block.sv | 42 ++++
 rtl/adder_16.sv | 121 ++++++++++++
 tb/tb_adder_16.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared constants and types for the adder_16 carry-lookahead adder.
//   - legal operand widths (4, 8, 16)
//   - CLA group size (4 bits)
//   - grp_pg_t : group propagate/generate pair produced by each cla4_block
//   - width_ok : elaboration-time check for a legal operand width
// -----------------------------------------------------------------------------
package adder_pkg;

  localparam int ADDER_W4  = 4;
  localparam int ADDER_W8  = 8;
  localparam int ADDER_W16 = 16;
  localparam int GRP_W     = 4;

  typedef struct packed {
    logic p;  // group propagate: carry-in passes through the whole group
    logic g;  // group generate: group produces a carry regardless of carry-in
  } grp_pg_t;

  function automatic bit width_ok(input int w);
    return (w == ADDER_W4) || (w == ADDER_W8) || (w == ADDER_W16);
  endfunction

endpackage

// File: rtl/cla4_block.sv
// -----------------------------------------------------------------------------
// cla4_block
// Purely combinational 4-bit carry-lookahead slice.
// Ports:
//   a, b : 4-bit operand slices
//   c0   : carry into bit 0 of this group
//   sum  : 4-bit sum slice
//   pg   : group propagate/generate, consumed by the second-level lookahead
// Group P/G do not depend on c0, so the upper lookahead level never waits on
// a group's own sum logic.
// -----------------------------------------------------------------------------
module cla4_block
  import adder_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             c0,
  output logic [GRP_W-1:0] sum,
  output grp_pg_t          pg
);

  logic [GRP_W-1:0] g;
  logic [GRP_W-1:0] p;
  logic [GRP_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is a flat sum of products of g/p and c0.
  assign c[0] = c0;
  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);

  assign sum = p ^ c;

  assign pg.p = &p;
  assign pg.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/adder_16.sv
// -----------------------------------------------------------------------------
// adder_16
// Two-level carry-lookahead adder with a registered output stage.
// {cout,out} = in1 + in2 + cin, captured one cycle after in_valid.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset (clears out/cout/out_valid[/ovf])
//   in_valid  : operands valid this cycle
//   cin       : carry-in
//   in1, in2  : WIDTH-bit operands
//   out       : registered sum (held while in_valid=0)
//   cout      : registered carry-out of the MSB (held while in_valid=0)
//   out_valid : high for the cycle after an accepted operation
//   ovf       : registered signed overflow, present only with ADDER_OVF_EN
// Optional feature macro: ADDER_OVF_EN
// -----------------------------------------------------------------------------
module adder_16
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             cin,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             cout,
`ifdef ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  localparam int NG = WIDTH / GRP_W;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("adder_16: WIDTH=%0d is illegal, must be 4, 8 or 16", WIDTH);
  end

  grp_pg_t          grp_pg [NG];
  logic [NG:0]      c_grp;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla4_block u_cla4 (
      .a   (in1[k*GRP_W +: GRP_W]),
      .b   (in2[k*GRP_W +: GRP_W]),
      .c0  (c_grp[k]),
      .sum (sum_d[k*GRP_W +: GRP_W]),
      .pg  (grp_pg[k])
    );
  end

  // Second-level lookahead: each group carry-in is expanded into a flat
  // sum of products of group G/P terms and cin, so no carry ripples between
  // groups. c_grp[NG] is the carry-out of the MSB.
  always_comb begin
    logic acc;
    logic term;
    c_grp = '0;
    c_grp[0] = cin;
    for (int k = 1; k <= NG; k++) begin
      term = cin;
      for (int j = 0; j < k; j++) term = term & grp_pg[j].p;
      acc = term;
      for (int j = 0; j < k; j++) begin
        term = grp_pg[j].g;
        for (int m = j + 1; m < k; m++) term = term & grp_pg[m].p;
        acc = acc | term;
      end
      c_grp[k] = acc;
    end
  end

  assign cout_d = c_grp[NG];

  logic [WIDTH-1:0] out_q;
  logic             cout_q;
  logic             vld_q;

  // Output stage: the only state in the design.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        out_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign out       = out_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

`ifdef ADDER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB is recovered from the MSB sum bit: p ^ sum = carry.
  assign ovf_d = (in1[WIDTH-1] ^ in2[WIDTH-1] ^ sum_d[WIDTH-1]) ^ cout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_16.sv
module tb_adder_16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v4, c4, v8, c8, v16, c16;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;

  logic [3:0]  o4;
  logic [7:0]  o8;
  logic [15:0] o16;
  logic        co4, co8, co16, vo4, vo8, vo16;
`ifdef ADDER_OVF_EN
  logic        ov4, ov8, ov16;
`endif

  adder_16 #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .cin(c4), .in1(a4), .in2(b4),
    .out(o4), .cout(co4),
`ifdef ADDER_OVF_EN
    .ovf(ov4),
`endif
    .out_valid(vo4));

  adder_16 #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .cin(c8), .in1(a8), .in2(b8),
    .out(o8), .cout(co8),
`ifdef ADDER_OVF_EN
    .ovf(ov8),
`endif
    .out_valid(vo8));

  adder_16 #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .cin(c16), .in1(a16), .in2(b16),
    .out(o16), .cout(co16),
`ifdef ADDER_OVF_EN
    .ovf(ov16),
`endif
    .out_valid(vo16));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Result packing: bits [w-1:0] sum,
  // bit w carry-out, bit w+1 signed overflow.
  function automatic int ref_add(input int w, input int a, input int b, input int c);
    int s, sa, sb, ss, r;
    bit of;
    s  = a + b + c;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    ss = sa + sb + c;
    of = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
    r  = (s & ((1 << w) - 1)) | ((s >> w) << w) | (int'(of) << (w + 1));
    return r;
  endfunction

  // Expected held state per instance.
  int m4, m8, m16;
  bit e4, e8, e16;

  task automatic model_reset();
    m4 = 0; m8 = 0; m16 = 0;
    e4 = 0; e8 = 0; e16 = 0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_w16_out"},  32'(o16),  32'(m16 & 16'hFFFF));
    chk({ph, "_w16_cout"}, 32'(co16), 32'((m16 >> 16) & 1));
    chk({ph, "_w16_vld"},  32'(vo16), 32'(e16));
    chk({ph, "_w8_out"},   32'(o8),   32'(m8 & 8'hFF));
    chk({ph, "_w8_cout"},  32'(co8),  32'((m8 >> 8) & 1));
    chk({ph, "_w8_vld"},   32'(vo8),  32'(e8));
    chk({ph, "_w4_out"},   32'(o4),   32'(m4 & 4'hF));
    chk({ph, "_w4_cout"},  32'(co4),  32'((m4 >> 4) & 1));
    chk({ph, "_w4_vld"},   32'(vo4),  32'(e4));
`ifdef ADDER_OVF_EN
    chk({ph, "_w16_ovf"},  32'(ov16), 32'((m16 >> 17) & 1));
    chk({ph, "_w8_ovf"},   32'(ov8),  32'((m8 >> 9) & 1));
    chk({ph, "_w4_ovf"},   32'(ov4),  32'((m4 >> 5) & 1));
`endif
  endtask

  // Advance one clock with the current inputs and check all outputs.
  task automatic tick(input string ph);
    e4 = v4; e8 = v8; e16 = v16;
    if (v4)  m4  = ref_add(4,  int'(a4),  int'(b4),  int'(c4));
    if (v8)  m8  = ref_add(8,  int'(a8),  int'(b8),  int'(c8));
    if (v16) m16 = ref_add(16, int'(a16), int'(b16), int'(c16));
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic idle_all();
    v4 = 0; v8 = 0; v16 = 0;
  endtask

  task automatic drv16(input logic [15:0] a, input logic [15:0] b, input logic c);
    v16 = 1; a16 = a; b16 = b; c16 = c;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    a4 = '0; b4 = '0; c4 = 0; a8 = '0; b8 = '0; c8 = 0;
    a16 = '0; b16 = '0; c16 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Directed WIDTH=16 corners.
    drv16(16'hFFFF, 16'h0001, 1'b0); tick("wrap16");
    chk("wrap16_out_direct", 32'(o16), 32'h0000);
    chk("wrap16_cout_direct", 32'(co16), 32'h1);
    drv16(16'h7FFF, 16'h0001, 1'b0); tick("ovf16");
    chk("ovf16_out_direct", 32'(o16), 32'h8000);
`ifdef ADDER_OVF_EN
    chk("ovf16_ovf_direct", 32'(ov16), 32'h1);
`endif
    drv16(16'h0FFF, 16'h0000, 1'b1); tick("chain16");
    chk("chain16_out_direct", 32'(o16), 32'h1000);
    drv16(16'h0000, 16'h0000, 1'b1); tick("cin16");
    chk("cin16_out_direct", 32'(o16), 32'h0001);
    idle_all();

    // WIDTH=8: A5+5A+1, then hold for 3 idle cycles.
    v8 = 1; a8 = 8'hA5; b8 = 8'h5A; c8 = 1; tick("w8op");
    chk("w8op_out_direct", 32'(o8), 32'h00);
    chk("w8op_cout_direct", 32'(co8), 32'h1);
    idle_all();
    for (int i = 0; i < 3; i++) tick("w8hold");

    // WIDTH=4 exhaustive, back-to-back.
    for (int i = 0; i < 512; i++) begin
      v4 = 1; a4 = i[3:0]; b4 = i[7:4]; c4 = i[8];
      tick("exh4");
    end
    idle_all();
    tick("exh4_end");

    // Randomized traffic on all three instances.
    for (int i = 0; i < 400; i++) begin
      v4  = 1'($urandom_range(0, 3) != 0);
      v8  = 1'($urandom_range(0, 3) != 0);
      v16 = 1'($urandom_range(0, 3) != 0);
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      if ((i % 16) == 0) begin
        a16 = 16'h8000; b16 = 16'h8000 - 16'(i % 2);
      end
      tick("rand");
    end

    // Reset asserted before the capturing edge of a valid operation.
    idle_all();
    drv16(16'h1234, 16'h1111, 1'b0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_imm");
    @(posedge clk);
    #1;
    check_all("rst_edge");
    idle_all();
    rst_n = 1'b1;
    tick("rst_rel");
    tick("rst_idle");
    drv16(16'h1234, 16'h1111, 1'b0); tick("rst_recover");
    chk("rst_recover_direct", 32'(o16), 32'h2345);
    idle_all();
    tick("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
